// File: rtl/poly_stream_ctrl_pkg.sv
// TYPES_KEM: shared ML-KEM types and default polynomial geometry.
//   ML_KEM_N        coefficients per polynomial
//   ML_KEM_COEFF_W  coefficient width in bits
//   ntt_mode_t      operation requested from the NTT core
package TYPES_KEM;

  localparam int ML_KEM_N       = 256;
  localparam int ML_KEM_COEFF_W = 12;

  typedef enum logic [1:0] {
    MODE_FNTT = 2'd0,
    MODE_INTT = 2'd1,
    MODE_PWM  = 2'd2
  } ntt_mode_t;

endpackage

// File: rtl/poly_stream_ctrl_serdes.sv
// poly_serdes: N*W register that is either loaded in parallel or shifted
// by one LANES*W beat toward bit 0, with the new beat entering at the top.
// Used as operand serialiser (parallel load, beats leave at beat_o) and as
// result deserialiser (beats enter at beat_i; after N/LANES shifts beat k
// sits in slot k).
//   clk_i, rst_i  clock, async active-high reset (clears the register)
//   load_i/par_i  parallel load, takes priority over shift
//   shift_i       shift one beat, beat_i enters the top slot
//   par_o         full register contents
//   beat_o        lowest beat (slot 0)
module poly_serdes #(
  parameter int N     = 256,
  parameter int W     = 12,
  parameter int LANES = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [N*W-1:0]       par_i,
  input  logic                 shift_i,
  input  logic [LANES*W-1:0]   beat_i,
  output logic [N*W-1:0]       par_o,
  output logic [LANES*W-1:0]   beat_o
);

  localparam int BW = LANES * W;
  localparam int RW = N * W;

  logic [RW-1:0] sr_q;

  generate
    if (BW == RW) begin : g_single_beat
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        sr_q <= '0;
        else if (load_i)  sr_q <= par_i;
        else if (shift_i) sr_q <= beat_i;
      end
    end else begin : g_multi_beat
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        sr_q <= '0;
        else if (load_i)  sr_q <= par_i;
        else if (shift_i) sr_q <= {beat_i, sr_q[RW-1:BW]};
      end
    end
  endgenerate

  assign par_o  = sr_q;
  assign beat_o = sr_q[BW-1:0];

endmodule

// File: rtl/poly_stream_ctrl.sv
// poly_stream_ctrl: streams operand polynomials into an NTT core beat by
// beat, starts the requested operation, waits for completion (with a
// timeout), then reads the result back and holds it on poly_r_o.
//   clk_i, rst_i            clock, async active-high reset
//   run_i, mode_i           start request and operation, sampled in IDLE
//   poly_a_i, poly_b_i      operands, captured on an accepted run_i
//   core_done_i             core completion pulse, honoured only in WAIT
//   dout_i                  result beat, valid RD_LAT cycles after read_o
//   load_a_o/load_b_o/din_o operand beat stream
//   start_*_o               one-cycle core start pulses
//   read_o                  result beat request
//   poly_r_o                last successfully read result
//   busy_o, done_o, err_o   status (busy decoded, pulses registered)
//
// state  | meaning
// IDLE   | waiting for run_i
// LOAD_A | streaming A beats (N/LANES cycles)
// LOAD_B | streaming B beats, PWM only (N/LANES cycles)
// START  | one-cycle start pulse for the captured mode
// WAIT   | waiting for core_done_i, bounded by TIMEOUT cycles
// READ   | N/LANES read requests plus RD_LAT drain cycles
// FIN    | one-cycle done pulse
module poly_stream_ctrl
  import TYPES_KEM::*;
#(
  parameter int N       = ML_KEM_N,
  parameter int W       = ML_KEM_COEFF_W,
  parameter int LANES   = 1,
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 run_i,
  input  ntt_mode_t            mode_i,
  input  logic [N*W-1:0]       poly_a_i,
  input  logic [N*W-1:0]       poly_b_i,
  input  logic                 core_done_i,
  input  logic [LANES*W-1:0]   dout_i,
  output logic                 load_a_o,
  output logic                 load_b_o,
  output logic [LANES*W-1:0]   din_o,
  output logic                 start_fntt_o,
  output logic                 start_intt_o,
  output logic                 start_pwm_o,
  output logic                 read_o,
  output logic [N*W-1:0]       poly_r_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int NB = N / LANES;
  localparam int CW = $clog2(NB + RD_LAT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LOAD_LAST = CW'(NB - 1);
  localparam logic [CW-1:0] READ_LAST = CW'(NB + RD_LAT - 1);
  localparam logic [CW-1:0] RD_LAT_C  = CW'(RD_LAT);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD_A, ST_LOAD_B, ST_START, ST_WAIT, ST_READ, ST_FIN
  } state_t;

  state_t          state_q, state_d;
  ntt_mode_t       mode_q;
  logic [N*W-1:0]  b_q;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic            accept;
  logic            ser_load;
  logic            ser_shift;
  logic [N*W-1:0]  ser_par;
  logic            cap;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_FNTT;
      b_q        <= '0;
      beat_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      to_cnt_q   <= to_cnt_d;
      if (accept) begin
        mode_q <= mode_i;
        b_q    <= poly_b_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (run_i) state_d = ST_LOAD_A;
      ST_LOAD_A: if (beat_cnt_q == '0)
                   state_d = (mode_q == MODE_PWM) ? ST_LOAD_B : ST_START;
      ST_LOAD_B: if (beat_cnt_q == '0) state_d = ST_START;
      ST_START:  state_d = ST_WAIT;
      ST_WAIT:   if (core_done_i)          state_d = ST_READ;
                 else if (to_cnt_q == '0)  state_d = ST_IDLE;
      ST_READ:   if (beat_cnt_q == '0) state_d = ST_FIN;
      ST_FIN:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Beat counter reloads on every state change, so LOAD_A -> LOAD_B
  // restarts the count for the B stream.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (state_d != state_q) begin
      if (state_d == ST_LOAD_A || state_d == ST_LOAD_B) beat_cnt_d = LOAD_LAST;
      else if (state_d == ST_READ)                       beat_cnt_d = READ_LAST;
      else                                               beat_cnt_d = '0;
    end else if (beat_cnt_q != '0) begin
      beat_cnt_d = beat_cnt_q - 1'b1;
    end
  end

  // Staying in WAIT implies to_cnt_q is nonzero, so the decrement never wraps.
  always_comb begin
    to_cnt_d = '0;
    if (state_d == ST_WAIT)
      to_cnt_d = (state_q == ST_WAIT) ? to_cnt_q - 1'b1 : TO_LAST;
  end

  // Outputs are registered from the next-state decode so they line up
  // exactly with the state they belong to.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      load_a_o     <= 1'b0;
      load_b_o     <= 1'b0;
      start_fntt_o <= 1'b0;
      start_intt_o <= 1'b0;
      start_pwm_o  <= 1'b0;
      read_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      load_a_o     <= (state_d == ST_LOAD_A);
      load_b_o     <= (state_d == ST_LOAD_B);
      start_fntt_o <= (state_d == ST_START) && (mode_q == MODE_FNTT);
      start_intt_o <= (state_d == ST_START) && (mode_q == MODE_INTT);
      start_pwm_o  <= (state_d == ST_START) && (mode_q == MODE_PWM);
      read_o       <= (state_d == ST_READ) && (beat_cnt_d >= RD_LAT_C);
      done_o       <= (state_d == ST_FIN);
      err_o        <= (state_q == ST_WAIT) && (state_d == ST_IDLE);
    end
  end

  assign busy_o = (state_q != ST_IDLE);

  // Read-latency delay line: cap marks the cycle in which dout_i carries
  // the beat requested RD_LAT cycles earlier.
  generate
    if (RD_LAT == 0) begin : g_no_rd_dly
      assign cap = read_o;
    end else begin : g_rd_dly
      logic [RD_LAT-1:0] dly_q;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) dly_q <= '0;
        else       dly_q <= RD_LAT'({dly_q, read_o});
      end
      assign cap = dly_q[RD_LAT-1];
    end
  endgenerate

  // The operand register is loaded with A on accept; on the last A beat of
  // a PWM run it is reloaded with B instead of shifting.
  assign accept    = (state_q == ST_IDLE) && run_i;
  assign ser_load  = accept || ((state_q == ST_LOAD_A) && (state_d == ST_LOAD_B));
  assign ser_par   = accept ? poly_a_i : b_q;
  assign ser_shift = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);

  poly_serdes #(.N(N), .W(W), .LANES(LANES)) u_operand_ser (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (ser_load),
    .par_i   (ser_par),
    .shift_i (ser_shift),
    .beat_i  ('0),
    .par_o   (),
    .beat_o  (din_o)
  );

  poly_serdes #(.N(N), .W(W), .LANES(LANES)) u_result_des (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (1'b0),
    .par_i   ('0),
    .shift_i (cap),
    .beat_i  (dout_i),
    .par_o   (poly_r_o),
    .beat_o  ()
  );

endmodule

// File: tb/tb_poly_stream_ctrl.sv
module tb_poly_stream_ctrl;
  import TYPES_KEM::*;

  localparam int N  = 256;
  localparam int W  = 12;
  localparam int BB = 4 * W;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // instance A: LANES=1, RD_LAT=2, TIMEOUT=4096
  logic            rst_a = 1'b1, run_a = 1'b0;
  ntt_mode_t       mode_a = MODE_FNTT;
  logic [N*W-1:0]  pa_a = '0, pb_a = '0;
  logic            cm_done_a = 1'b0, inj_done_a = 1'b0, core_done_a;
  logic [W-1:0]    dout_a = '0, din_a;
  logic            la_a, lb_a, sf_a, si_a, sp_a, read_a, busy_a, done_a, err_a;
  logic [N*W-1:0]  pr_a;
  assign core_done_a = cm_done_a | inj_done_a;

  // instance B: LANES=4, RD_LAT=2, TIMEOUT=16
  logic            rst_b = 1'b1, run_b = 1'b0;
  ntt_mode_t       mode_b = MODE_PWM;
  logic [N*W-1:0]  pa_b = '0, pb_b = '0;
  logic            cm_done_b = 1'b0, core_en_b = 1'b0;
  logic [BB-1:0]   dout_b = '0, din_b;
  logic            la_b, lb_b, sf_b, si_b, sp_b, read_b, busy_b, done_b, err_b;
  logic [N*W-1:0]  pr_b;

  poly_stream_ctrl #(.N(N), .W(W), .LANES(1), .RD_LAT(2), .TIMEOUT(4096)) dut_a (
    .clk_i(clk_i), .rst_i(rst_a), .run_i(run_a), .mode_i(mode_a),
    .poly_a_i(pa_a), .poly_b_i(pb_a), .core_done_i(core_done_a), .dout_i(dout_a),
    .load_a_o(la_a), .load_b_o(lb_a), .din_o(din_a),
    .start_fntt_o(sf_a), .start_intt_o(si_a), .start_pwm_o(sp_a),
    .read_o(read_a), .poly_r_o(pr_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a));

  poly_stream_ctrl #(.N(N), .W(W), .LANES(4), .RD_LAT(2), .TIMEOUT(16)) dut_b (
    .clk_i(clk_i), .rst_i(rst_b), .run_i(run_b), .mode_i(mode_b),
    .poly_a_i(pa_b), .poly_b_i(pb_b), .core_done_i(cm_done_b), .dout_i(dout_b),
    .load_a_o(la_b), .load_b_o(lb_b), .din_o(din_b),
    .start_fntt_o(sf_b), .start_intt_o(si_b), .start_pwm_o(sp_b),
    .read_o(read_b), .poly_r_o(pr_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b));

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // negedge monitor: event counters plus the core's read-data model
  int ncyc = 0;
  int la_cnt_a = 0, lb_cnt_a = 0, sf_cnt_a = 0, si_cnt_a = 0, sp_cnt_a = 0;
  int done_cnt_a = 0, la_first_a = 0, done_cyc_a = 0, wk_a = 0, kr_a = 0;
  logic prev_la_a = 1'b0;
  logic [7:0] hist_a = '0;
  logic [W-1:0] echo_a [N];
  int la_cnt_b = 0, lb_cnt_b = 0, sf_cnt_b = 0, si_cnt_b = 0, sp_cnt_b = 0;
  int done_cnt_b = 0, err_cnt_b = 0, la_first_b = 0, lb_first_b = 0;
  int si_cyc_b = 0, err_cyc_b = 0, kr_b = 0;
  logic prev_la_b = 1'b0, prev_lb_b = 1'b0;
  logic [BB-1:0] first_la_din_b = '0, first_lb_din_b = '0;
  logic [7:0] hist_b = '0;

  always @(negedge clk_i) begin
    ncyc++;
    if (la_a) begin
      if (!prev_la_a) begin wk_a = 0; la_first_a = ncyc; end
      if (wk_a < N) echo_a[wk_a] = din_a;
      wk_a++;
      la_cnt_a++;
    end
    prev_la_a = la_a;
    if (lb_a) lb_cnt_a++;
    if (sf_a) sf_cnt_a++;
    if (si_a) si_cnt_a++;
    if (sp_a) sp_cnt_a++;
    if (sf_a | si_a | sp_a) kr_a = 0;
    if (done_a) begin done_cnt_a++; done_cyc_a = ncyc; end
    hist_a = {hist_a[6:0], read_a};
    if (hist_a[2]) begin
      if (kr_a < N) dout_a = echo_a[kr_a];
      kr_a++;
    end

    if (la_b) begin
      if (!prev_la_b) begin la_first_b = ncyc; first_la_din_b = din_b; end
      la_cnt_b++;
    end
    prev_la_b = la_b;
    if (lb_b) begin
      if (!prev_lb_b) begin lb_first_b = ncyc; first_lb_din_b = din_b; end
      lb_cnt_b++;
    end
    prev_lb_b = lb_b;
    if (sf_b) sf_cnt_b++;
    if (si_b) begin si_cnt_b++; si_cyc_b = ncyc; end
    if (sp_b) sp_cnt_b++;
    if (sf_b | si_b | sp_b) kr_b = 0;
    if (done_b) done_cnt_b++;
    if (err_b) begin err_cnt_b++; err_cyc_b = ncyc; end
    hist_b = {hist_b[6:0], read_b};
    if (hist_b[2]) begin
      for (int j = 0; j < 4; j++) dout_b[j*W +: W] = W'(kr_b * 4 + j + 100);
      kr_b++;
    end
  end

  // core models: completion D cycles after the start pulse cycle
  initial begin : core_model_a
    forever begin
      @(negedge clk_i);
      if (sf_a | si_a | sp_a) begin
        repeat (100) @(negedge clk_i);
        cm_done_a = 1'b1;
        @(negedge clk_i);
        cm_done_a = 1'b0;
      end
    end
  end

  initial begin : core_model_b
    forever begin
      @(negedge clk_i);
      if ((sf_b | si_b | sp_b) && core_en_b) begin
        repeat (5) @(negedge clk_i);
        cm_done_b = 1'b1;
        @(negedge clk_i);
        cm_done_b = 1'b0;
      end
    end
  end

  initial begin : main
    int s_la, s_lb, s_sf, s_si, s_sp, s_done, s_err, nerr;
    logic seen;
    logic [N*W-1:0] keep_b;

    for (int i = 0; i < N; i++) begin
      pa_a[i*W +: W] = W'(i);
      pa_b[i*W +: W] = W'(i);
      pb_b[i*W +: W] = W'(3328 - i);
    end

    // reset state
    repeat (3) tick();
    chk("rst_busy", busy_a, 0);
    chk("rst_load_a", la_a, 0);
    chk("rst_load_b", lb_a, 0);
    chk("rst_din", din_a, 0);
    chk("rst_starts", {sf_a, si_a, sp_a}, 0);
    chk("rst_read", read_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_poly", |pr_a, 0);
    chk("rst_b_busy", busy_b, 0);
    chk("rst_b_din", din_b, 0);

    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();

    // op1: FNTT with run held high for the whole operation
    s_la = la_cnt_a; s_lb = lb_cnt_a; s_sf = sf_cnt_a; s_si = si_cnt_a;
    s_sp = sp_cnt_a; s_done = done_cnt_a;
    run_a = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin tick(); seen = done_a; end
    chk("op1_done_seen", seen, 1);
    tick();
    chk("op1_fin_idle", busy_a, 0);
    chk("op1_load_a_cnt", la_cnt_a - s_la, 256);
    chk("op1_load_b_cnt", lb_cnt_a - s_lb, 0);
    chk("op1_fntt_pulses", sf_cnt_a - s_sf, 1);
    chk("op1_other_pulses", (si_cnt_a - s_si) + (sp_cnt_a - s_sp), 0);
    chk("op1_done_cnt", done_cnt_a - s_done, 1);
    chk("op1_done_latency", done_cyc_a - la_first_a, 615);
    nerr = 0;
    for (int i = 0; i < N; i++) if (pr_a[i*W +: W] !== W'(i)) nerr++;
    chk("op1_poly_errs", nerr, 0);
    chk("op1_coef200", pr_a[200*W +: W], 200);
    tick();
    chk("op2_accept_busy", busy_a, 1);
    chk("op2_accept_load", la_a, 1);
    run_a = 1'b0;
    for (int i = 0; i < N; i++) pa_a[i*W +: W] = W'(i * 37 + 5);

    // reset in the middle of LOAD_A
    repeat (99) tick();
    chk("op2_still_loading", la_a, 1);
    rst_a = 1'b1;
    #1;
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_load_a", la_a, 0);
    chk("mid_rst_din", din_a, 0);
    chk("mid_rst_poly", |pr_a, 0);
    chk("mid_rst_pulses", {sf_a, si_a, sp_a, read_a, done_a, err_a}, 0);
    tick();

    // op3: run on the first edge after reset release, stray core_done in LOAD_A
    rst_a = 1'b0;
    run_a = 1'b1;
    s_la = la_cnt_a; s_sf = sf_cnt_a; s_done = done_cnt_a;
    tick();
    run_a = 1'b0;
    chk("op3_first_edge_accept", la_a, 1);
    repeat (10) tick();
    inj_done_a = 1'b1;
    tick();
    inj_done_a = 1'b0;
    chk("op3_done_ignored", la_a, 1);
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin tick(); seen = done_a; end
    chk("op3_done_seen", seen, 1);
    tick();
    chk("op3_load_a_cnt", la_cnt_a - s_la, 256);
    chk("op3_fntt_pulses", sf_cnt_a - s_sf, 1);
    chk("op3_done_cnt", done_cnt_a - s_done, 1);
    chk("op3_done_latency", done_cyc_a - la_first_a, 615);
    nerr = 0;
    for (int i = 0; i < N; i++) if (pr_a[i*W +: W] !== W'(i * 37 + 5)) nerr++;
    chk("op3_poly_errs", nerr, 0);

    // PWM on the 4-lane instance
    s_la = la_cnt_b; s_lb = lb_cnt_b; s_sf = sf_cnt_b; s_sp = sp_cnt_b;
    s_done = done_cnt_b;
    core_en_b = 1'b1;
    mode_b = MODE_PWM;
    run_b = 1'b1;
    tick();
    run_b = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 1000 && !seen; c++) begin tick(); seen = done_b; end
    chk("pwm_done_seen", seen, 1);
    tick();
    chk("pwm_load_a_cnt", la_cnt_b - s_la, 64);
    chk("pwm_load_b_cnt", lb_cnt_b - s_lb, 64);
    chk("pwm_b_follows_a", lb_first_b - la_first_b, 64);
    chk("pwm_first_a_beat", first_la_din_b, {12'd3, 12'd2, 12'd1, 12'd0});
    chk("pwm_first_b_beat", first_lb_din_b, {12'd3325, 12'd3326, 12'd3327, 12'd3328});
    chk("pwm_pulses", sp_cnt_b - s_sp, 1);
    chk("pwm_no_fntt", sf_cnt_b - s_sf, 0);
    chk("pwm_done_cnt", done_cnt_b - s_done, 1);
    nerr = 0;
    for (int i = 0; i < N; i++) if (pr_b[i*W +: W] !== W'(i + 100)) nerr++;
    chk("pwm_poly_errs", nerr, 0);

    // INTT with a silent core: timeout after 16 WAIT cycles
    keep_b = pr_b;
    s_lb = lb_cnt_b; s_si = si_cnt_b; s_done = done_cnt_b; s_err = err_cnt_b;
    core_en_b = 1'b0;
    mode_b = MODE_INTT;
    run_b = 1'b1;
    tick();
    run_b = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin tick(); seen = err_b; end
    chk("intt_err_seen", seen, 1);
    tick();
    chk("intt_err_cnt", err_cnt_b - s_err, 1);
    chk("intt_err_delay", err_cyc_b - si_cyc_b, 17);
    chk("intt_pulses", si_cnt_b - s_si, 1);
    chk("intt_no_load_b", lb_cnt_b - s_lb, 0);
    chk("intt_no_done", done_cnt_b - s_done, 0);
    chk("intt_idle", busy_b, 0);
    chk("intt_poly_kept", pr_b !== keep_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
